load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum number of cycles ACCESS waits for mem_ack before it aborts.
REQ-002 clock  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  pipeline presents an access.
REQ-005 req_ready  output  1  unit can accept an access.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
REQ-008 req_signed  input  1  load extension: 1 = sign-extend, 0 = zero-extend.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_data  output  32  extended load data; this is the memory-data input of the writeback select.
REQ-013 resp_err  output  2  00 = ok, 01 = misaligned, 10 = timeout; valid with resp_valid.
REQ-014 mem_req  output  1  memory access request.
REQ-015 mem_we  output  1  memory write enable.
REQ-016 mem_be  output  4  byte enables, little-endian; bit 0 = addr[1:0] 00.
REQ-017 mem_addr  output  32  word address: req_addr with bits [1:0] forced to 00.
REQ-018 mem_wdata  output  32  lane-replicated store data.
REQ-019 mem_ack  input  1  memory completed the access this cycle.
REQ-020 mem_rdata  input  32  read word; valid when mem_ack = 1.

Function
REQ-021 The FSM SHALL have three states: IDLE, ACCESS and RESPOND.
REQ-022 In IDLE, req_ready SHALL be 1; in every other state it SHALL be 0.
REQ-023 When req_valid and req_ready are both 1, the unit SHALL register write, size, signed, addr[1:0] and the lane-prepared wdata/be, then change state.
REQ-024 An access SHALL be misaligned when it is a half with addr[0] = 1, or a word with addr[1:0] != 00.
REQ-025 A misaligned access SHALL go directly to RESPOND with resp_err = 01 and resp_data = 0, and mem_req SHALL never assert for it.
REQ-026 An aligned access SHALL go to ACCESS and clear the timeout counter.
REQ-027 In ACCESS, mem_req SHALL be 1, and mem_addr, mem_we, mem_be and mem_wdata SHALL be held stable until the cycle in which mem_ack = 1.
REQ-028 When mem_ack is sampled at 1 in ACCESS, the FSM SHALL go to RESPOND; for a load it SHALL capture mem_rdata in that same edge.
REQ-029 Byte enables SHALL be: byte 0001 shifted left by addr[1:0]; half 0011 shifted left by addr[1]*2; word 1111.
REQ-030 mem_wdata SHALL be: byte = wdata[7:0] replicated ×4; half = wdata[15:0] replicated ×2; word = wdata.
REQ-031 Load data SHALL be extracted from the addressed lane, then sign- or zero-extended to 32 bits according to req_signed.
REQ-032 For a store, resp_data SHALL be 0.
REQ-033 In ACCESS, the counter SHALL increment every cycle without mem_ack.
REQ-034 When the counter reaches TIMEOUT with no ack, the FSM SHALL go to RESPOND with resp_err = 10 and resp_data = 0.
REQ-035 If mem_ack arrives in the same cycle the counter reaches TIMEOUT, the ack SHALL win: resp_err = 00 and the data is captured.
REQ-036 RESPOND SHALL last exactly one cycle, with resp_valid = 1 and resp_data/resp_err registered, then return to IDLE.
REQ-037 Latency: acceptance at edge N, mem_ack at edge N+k (k >= 1), resp_valid high in the cycle after edge N+k.
REQ-038 A misaligned access SHALL have resp_valid high in the cycle after acceptance.
REQ-039 mem_ack seen outside ACCESS SHALL be ignored.
REQ-040 req_valid seen outside IDLE SHALL be ignored, with no queueing.

Reset
REQ-041 Reset SHALL take effect asynchronously, from any state including mid-ACCESS.
REQ-042 During reset: state = IDLE, req_ready = 1, resp_valid = 0, resp_data = 0, resp_err = 00, mem_req = 0, mem_we = 0, mem_be = 0000, mem_addr = 0, mem_wdata = 0, counter = 0.
REQ-043 An access interrupted by reset SHALL be dropped with no response.

Structure
REQ-044 The shared package SHALL hold the size codes, the error codes and the state encoding.
REQ-045 Lane extraction and extension (REQ-031) SHALL be one combinational sub-module, load_extend.
REQ-046 All outputs SHALL be registered, except req_ready, which is decoded from the state.

Verification
REQ-047 Aligned word load: addr 0x100, mem_ack after 3 cycles, rdata 0xDEADBEEF -> mem_addr 0x100, be 1111, resp_data 0xDEADBEEF, err 00.
REQ-048 Signed byte load: addr 0x103, rdata 0x80FF7F01 -> be 1000, resp_data 0xFFFFFF80; the same access unsigned -> 0x00000080.
REQ-049 Half store: addr 0x202, wdata 0x0000ABCD, ack on first cycle -> mem_we 1, be 1100, mem_wdata 0xABCDABCD, resp_valid 2 cycles after acceptance.
REQ-050 Misaligned word: addr 0x101 -> mem_req never 1, resp_err 01 in the next cycle; back-to-back req_valid is ignored until IDLE.
REQ-051 No ack with TIMEOUT = 15 -> resp_err 10 after 15 ACCESS cycles; ack on cycle 15 -> err 00 with the data captured.
REQ-052 Reset asserted mid-ACCESS -> all outputs return to their reset values immediately, and no resp_valid follows.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the load/store unit.
//   Size codes, response error codes and FSM state encoding, the captured
//   request descriptor, and lane-preparation helpers for stores.
package load_store_unit_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned BE_W = XLEN / 8;

   typedef enum logic [1:0] {
      SZ_BYTE     = 2'b00,
      SZ_HALF     = 2'b01,
      SZ_WORD     = 2'b10,
      SZ_WORD_ALT = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      ERR_OK       = 2'b00,
      ERR_MISALIGN = 2'b01,
      ERR_TIMEOUT  = 2'b10
   } err_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_ACCESS  = 2'b01,
      ST_RESPOND = 2'b10
   } state_e;

   // Request attributes kept for the duration of one access
   typedef struct packed {
      logic       write;
      size_e      size;
      logic       sgn;
      logic [1:0] lo;
   } acc_t;

   function automatic logic is_misaligned(input size_e size, input logic [1:0] lo);
      unique case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return lo[0];
         default: return (lo != 2'b00);
      endcase
   endfunction

   function automatic logic [BE_W-1:0] lane_be(input size_e size, input logic [1:0] lo);
      unique case (size)
         SZ_BYTE: return BE_W'(4'b0001 << lo);
         SZ_HALF: return BE_W'(4'b0011 << {lo[1], 1'b0});
         default: return {BE_W{1'b1}};
      endcase
   endfunction

   function automatic logic [XLEN-1:0] lane_wdata(input size_e size, input logic [XLEN-1:0] wdata);
      unique case (size)
         SZ_BYTE: return {4{wdata[7:0]}};
         SZ_HALF: return {2{wdata[15:0]}};
         default: return wdata;
      endcase
   endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Load lane extraction and sign/zero extension.
//   rdata  : raw memory word
//   size   : access size
//   sgn    : 1 = sign-extend, 0 = zero-extend
//   lo     : byte offset within the word
//   data_c : right-aligned, extended load data (combinational)
module load_extend
   import load_store_unit_pkg::*;
(
   input  logic [XLEN-1:0] rdata,
   input  size_e           size,
   input  logic            sgn,
   input  logic [1:0]      lo,
   output logic [XLEN-1:0] data_c
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      data_c = rdata;
      lane_b = rdata[{lo, 3'b000} +: 8];
      lane_h = lo[1] ? rdata[31:16] : rdata[15:0];
      unique case (size)
         SZ_BYTE: data_c = {{24{sgn & lane_b[7]}}, lane_b};
         SZ_HALF: data_c = {{16{sgn & lane_h[15]}}, lane_h};
         default: data_c = rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding access between pipeline and memory.
//   req_*  : access request from the pipeline (accepted while req_ready)
//   resp_* : one-cycle completion pulse with extended load data and error code
//   mem_*  : word-addressed memory port with byte enables and ack
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_write,
   input  logic [1:0]      req_size,
   input  logic            req_signed,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            resp_valid,
   output logic [XLEN-1:0] resp_data,
   output logic [1:0]      resp_err,
   output logic            mem_req,
   output logic            mem_we,
   output logic [BE_W-1:0] mem_be,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic            mem_ack,
   input  logic [XLEN-1:0] mem_rdata
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   state_e            state_q, state_d;
   acc_t              acc_q;
   logic [CNT_W-1:0]  cnt_q;
   size_e             size_in;
   logic              mis;
   logic              timeout_hit;
   logic [XLEN-1:0]   ld_data_c;

   assign size_in     = size_e'(req_size);
   assign mis         = is_misaligned(size_in, req_addr[1:0]);
   // Counter holds the number of ack-less ACCESS cycles already completed
   assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

   load_extend u_load_extend (
      .rdata  (mem_rdata),
      .size   (acc_q.size),
      .sgn    (acc_q.sgn),
      .lo     (acc_q.lo),
      .data_c (ld_data_c)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; ack takes priority over timeout
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:    if (req_valid) state_d = mis ? ST_RESPOND : ST_ACCESS;
         ST_ACCESS:  if (mem_ack || timeout_hit) state_d = ST_RESPOND;
         ST_RESPOND: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // State-decoded output
   always_comb begin
      req_ready = 1'b0;
      if (state_q == ST_IDLE) req_ready = 1'b1;
   end

   // Registered datapath and outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q      <= '0;
         cnt_q      <= '0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_err   <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_be     <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         resp_valid <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  acc_q <= '{write: req_write, size: size_in, sgn: req_signed, lo: req_addr[1:0]};
                  cnt_q <= '0;
                  if (mis) begin
                     resp_valid <= 1'b1;
                     resp_err   <= ERR_MISALIGN;
                     resp_data  <= '0;
                  end else begin
                     mem_req   <= 1'b1;
                     mem_we    <= req_write;
                     mem_be    <= lane_be(size_in, req_addr[1:0]);
                     mem_addr  <= {req_addr[XLEN-1:2], 2'b00};
                     mem_wdata <= lane_wdata(size_in, req_wdata);
                  end
               end
            end
            ST_ACCESS: begin
               if (mem_ack) begin
                  mem_req    <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= ERR_OK;
                  resp_data  <= acc_q.write ? '0 : ld_data_c;
               end else if (timeout_hit) begin
                  mem_req    <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= ERR_TIMEOUT;
                  resp_data  <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (TIMEOUT = 15).
module tb_load_store_unit;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic [1:0]  resp_err;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int n_vec = 0;
   int n_err = 0;

   load_store_unit #(.TIMEOUT(15)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .resp_err   (resp_err),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_be     (mem_be),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one request; returns 1 time unit after the acceptance edge
   task automatic send(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = w;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = wd;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
   endtask

   // Ack sampled k edges after acceptance; returns 1 time unit after that edge
   task automatic drive_ack(input int k, input logic [31:0] rd);
      for (int i = 0; i < k; i++) @(negedge clk);
      mem_ack   = 1'b1;
      mem_rdata = rd;
      @(posedge clk);
      #1;
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
   endtask

   task automatic test_reset;
      #1;
      n_vec++; if (req_ready !== 1'b1)  begin n_err++; $display("FAIL reset req_ready: got %b want 1", req_ready); end
      n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset resp_valid: got %b want 0", resp_valid); end
      n_vec++; if (mem_req !== 1'b0)    begin n_err++; $display("FAIL reset mem_req: got %b want 0", mem_req); end
      n_vec++; if (mem_be !== 4'b0000)  begin n_err++; $display("FAIL reset mem_be: got %b want 0000", mem_be); end
      n_vec++; if (mem_addr !== 32'h0)  begin n_err++; $display("FAIL reset mem_addr: got %h want 0", mem_addr); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_word_load;
      send(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
      n_vec++; if (mem_req !== 1'b1)          begin n_err++; $display("FAIL wload mem_req: got %b want 1", mem_req); end
      n_vec++; if (mem_addr !== 32'h100)      begin n_err++; $display("FAIL wload mem_addr: got %h want 00000100", mem_addr); end
      n_vec++; if (mem_be !== 4'b1111)        begin n_err++; $display("FAIL wload mem_be: got %b want 1111", mem_be); end
      n_vec++; if (mem_we !== 1'b0)           begin n_err++; $display("FAIL wload mem_we: got %b want 0", mem_we); end
      n_vec++; if (req_ready !== 1'b0)        begin n_err++; $display("FAIL wload req_ready: got %b want 0", req_ready); end
      drive_ack(3, 32'hDEAD_BEEF);
      n_vec++; if (resp_valid !== 1'b1)       begin n_err++; $display("FAIL wload resp_valid: got %b want 1", resp_valid); end
      n_vec++; if (resp_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL wload resp_data: got %h want deadbeef", resp_data); end
      n_vec++; if (resp_err !== 2'b00)        begin n_err++; $display("FAIL wload resp_err: got %b want 00", resp_err); end
      n_vec++; if (mem_req !== 1'b0)          begin n_err++; $display("FAIL wload mem_req after ack: got %b want 0", mem_req); end
      @(posedge clk); #1;
      n_vec++; if (resp_valid !== 1'b0)       begin n_err++; $display("FAIL wload resp pulse width: got %b want 0", resp_valid); end
      n_vec++; if (req_ready !== 1'b1)        begin n_err++; $display("FAIL wload back to idle: got %b want 1", req_ready); end
   endtask

   task automatic test_byte_load;
      send(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0);
      n_vec++; if (mem_be !== 4'b1000)         begin n_err++; $display("FAIL sbyte mem_be: got %b want 1000", mem_be); end
      n_vec++; if (mem_addr !== 32'h100)       begin n_err++; $display("FAIL sbyte mem_addr: got %h want 00000100", mem_addr); end
      drive_ack(1, 32'h80FF_7F01);
      n_vec++; if (resp_data !== 32'hFFFFFF80) begin n_err++; $display("FAIL sbyte resp_data: got %h want ffffff80", resp_data); end
      @(posedge clk); #1;
      send(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0);
      drive_ack(2, 32'h80FF_7F01);
      n_vec++; if (resp_data !== 32'h00000080) begin n_err++; $display("FAIL ubyte resp_data: got %h want 00000080", resp_data); end
      @(posedge clk); #1;
      send(1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0);
      n_vec++; if (mem_be !== 4'b1100)         begin n_err++; $display("FAIL shalf mem_be: got %b want 1100", mem_be); end
      drive_ack(1, 32'h80FF_7F01);
      n_vec++; if (resp_data !== 32'hFFFF80FF) begin n_err++; $display("FAIL shalf resp_data: got %h want ffff80ff", resp_data); end
      @(posedge clk); #1;
   endtask

   task automatic test_half_store;
      send(1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_ABCD);
      n_vec++; if (mem_we !== 1'b1)            begin n_err++; $display("FAIL hstore mem_we: got %b want 1", mem_we); end
      n_vec++; if (mem_be !== 4'b1100)         begin n_err++; $display("FAIL hstore mem_be: got %b want 1100", mem_be); end
      n_vec++; if (mem_wdata !== 32'hABCDABCD) begin n_err++; $display("FAIL hstore mem_wdata: got %h want abcdabcd", mem_wdata); end
      n_vec++; if (mem_addr !== 32'h200)       begin n_err++; $display("FAIL hstore mem_addr: got %h want 00000200", mem_addr); end
      drive_ack(1, 32'h1234_5678);
      n_vec++; if (resp_valid !== 1'b1)        begin n_err++; $display("FAIL hstore resp_valid: got %b want 1", resp_valid); end
      n_vec++; if (resp_data !== 32'h0)        begin n_err++; $display("FAIL hstore resp_data: got %h want 0", resp_data); end
      @(posedge clk); #1;
      send(1'b1, 2'b00, 1'b0, 32'h0000_0301, 32'h0000_005A);
      n_vec++; if (mem_be !== 4'b0010)         begin n_err++; $display("FAIL bstore mem_be: got %b want 0010", mem_be); end
      n_vec++; if (mem_wdata !== 32'h5A5A5A5A) begin n_err++; $display("FAIL bstore mem_wdata: got %h want 5a5a5a5a", mem_wdata); end
      drive_ack(1, 32'h0);
      @(posedge clk); #1;
   endtask

   task automatic test_misaligned;
      send(1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0);
      // Second request presented while the first is responding must be dropped
      req_valid = 1'b1;
      req_addr  = 32'h0000_0100;
      req_size  = 2'b10;
      req_write = 1'b0;
      n_vec++; if (mem_req !== 1'b0)     begin n_err++; $display("FAIL misalign mem_req: got %b want 0", mem_req); end
      n_vec++; if (resp_valid !== 1'b1)  begin n_err++; $display("FAIL misalign resp_valid: got %b want 1", resp_valid); end
      n_vec++; if (resp_err !== 2'b01)   begin n_err++; $display("FAIL misalign resp_err: got %b want 01", resp_err); end
      n_vec++; if (resp_data !== 32'h0)  begin n_err++; $display("FAIL misalign resp_data: got %h want 0", resp_data); end
      n_vec++; if (req_ready !== 1'b0)   begin n_err++; $display("FAIL misalign req_ready: got %b want 0", req_ready); end
      @(posedge clk); #1;
      req_valid = 1'b0;
      n_vec++; if (mem_req !== 1'b0)     begin n_err++; $display("FAIL b2b ignored mem_req: got %b want 0", mem_req); end
      n_vec++; if (resp_valid !== 1'b0)  begin n_err++; $display("FAIL b2b ignored resp_valid: got %b want 0", resp_valid); end
      n_vec++; if (req_ready !== 1'b1)   begin n_err++; $display("FAIL b2b back to idle: got %b want 1", req_ready); end
      send(1'b0, 2'b01, 1'b0, 32'h0000_0103, 32'h0);
      n_vec++; if (resp_err !== 2'b01)   begin n_err++; $display("FAIL misalign half resp_err: got %b want 01", resp_err); end
      n_vec++; if (mem_req !== 1'b0)     begin n_err++; $display("FAIL misalign half mem_req: got %b want 0", mem_req); end
      @(posedge clk); #1;
   endtask

   task automatic test_stray_ack;
      @(negedge clk);
      mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      n_vec++; if (resp_valid !== 1'b0)  begin n_err++; $display("FAIL stray ack resp_valid: got %b want 0", resp_valid); end
      n_vec++; if (req_ready !== 1'b1)   begin n_err++; $display("FAIL stray ack req_ready: got %b want 1", req_ready); end
   endtask

   task automatic test_timeout;
      send(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0);
      repeat (14) @(posedge clk);
      #1;
      n_vec++; if (resp_valid !== 1'b0)  begin n_err++; $display("FAIL timeout early resp_valid: got %b want 0", resp_valid); end
      n_vec++; if (mem_req !== 1'b1)     begin n_err++; $display("FAIL timeout mem_req held: got %b want 1", mem_req); end
      n_vec++; if (mem_addr !== 32'h400) begin n_err++; $display("FAIL timeout mem_addr held: got %h want 00000400", mem_addr); end
      @(posedge clk); #1;
      n_vec++; if (resp_valid !== 1'b1)  begin n_err++; $display("FAIL timeout resp_valid: got %b want 1", resp_valid); end
      n_vec++; if (resp_err !== 2'b10)   begin n_err++; $display("FAIL timeout resp_err: got %b want 10", resp_err); end
      n_vec++; if (resp_data !== 32'h0)  begin n_err++; $display("FAIL timeout resp_data: got %h want 0", resp_data); end
      n_vec++; if (mem_req !== 1'b0)     begin n_err++; $display("FAIL timeout mem_req dropped: got %b want 0", mem_req); end
      @(posedge clk); #1;
   endtask

   task automatic test_ack_at_timeout;
      send(1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0);
      drive_ack(15, 32'h1234_5678);
      n_vec++; if (resp_valid !== 1'b1)        begin n_err++; $display("FAIL ack@15 resp_valid: got %b want 1", resp_valid); end
      n_vec++; if (resp_err !== 2'b00)         begin n_err++; $display("FAIL ack@15 resp_err: got %b want 00", resp_err); end
      n_vec++; if (resp_data !== 32'h12345678) begin n_err++; $display("FAIL ack@15 resp_data: got %h want 12345678", resp_data); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_access;
      send(1'b1, 2'b10, 1'b0, 32'h0000_0600, 32'hCAFE_F00D);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      n_vec++; if (mem_req !== 1'b0)      begin n_err++; $display("FAIL midrst mem_req: got %b want 0", mem_req); end
      n_vec++; if (mem_we !== 1'b0)       begin n_err++; $display("FAIL midrst mem_we: got %b want 0", mem_we); end
      n_vec++; if (mem_be !== 4'b0000)    begin n_err++; $display("FAIL midrst mem_be: got %b want 0000", mem_be); end
      n_vec++; if (mem_addr !== 32'h0)    begin n_err++; $display("FAIL midrst mem_addr: got %h want 0", mem_addr); end
      n_vec++; if (mem_wdata !== 32'h0)   begin n_err++; $display("FAIL midrst mem_wdata: got %h want 0", mem_wdata); end
      n_vec++; if (req_ready !== 1'b1)    begin n_err++; $display("FAIL midrst req_ready: got %b want 1", req_ready); end
      n_vec++; if (resp_data !== 32'h0)   begin n_err++; $display("FAIL midrst resp_data: got %h want 0", resp_data); end
      @(negedge clk);
      rst_n   = 1'b1;
      mem_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL midrst no response cycle %0d: got %b want 0", i, resp_valid); end
      end
      mem_ack = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_size   = 2'b00;
      req_signed = 1'b0;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      mem_ack    = 1'b0;
      mem_rdata  = 32'h0;
      test_reset;
      test_word_load;
      test_byte_load;
      test_half_store;
      test_misaligned;
      test_stray_ack;
      test_timeout;
      test_ack_at_timeout;
      test_reset_mid_access;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
